// File: rtl/rot_pkg.sv
// Shared types and constants for the rotating-key decode controller.
package rot_pkg;

  localparam int unsigned ROT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/BarrelShifter.sv
// 8-bit rotate-right; an amount of 8..15 wraps modulo 8.
module BarrelShifter (
  input  logic [7:0] data_in,
  input  logic [3:0] rot_amt,
  output logic [7:0] data_out
);

  always_comb begin
    data_out = '0;
    for (int j = 0; j < 8; j++) begin
      data_out[j] = data_in[3'(j + int'(rot_amt))];
    end
  end

endmodule

// File: rtl/rot_decode_ctrl.sv
// Reads msg_len bytes, rotates each right by a per-byte stepping amount and writes them back out.
module rot_decode_ctrl
  import rot_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [7:0]        msg_len,
  input  logic [3:0]        key,
  input  logic [2:0]        key_step,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [7:0]         len_q, len_d;
  logic [ROT_W-1:0]   step_q, step_d;
  logic [ROT_W-1:0]   rot_q, rot_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         shifted;
  logic               unused_key3;

  assign unused_key3 = key[3];

  BarrelShifter u_shift (
    .data_in  (rd_data),
    .rot_amt  ({1'b0, rot_q}),
    .data_out (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      step_q  <= '0;
      rot_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      step_q  <= step_d;
      rot_q   <= rot_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    step_d  = step_q;
    rot_d   = rot_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = msg_len;
          step_d  = key_step;
          rot_d   = key[ROT_W-1:0];
          idx_d   = '0;
          state_d = (msg_len != 8'd0) ? READ : DONE;
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        wdata_d = shifted;
        state_d = WRITE;
      end
      WRITE: begin
        rot_d = rot_q + step_q;
        // Index holds on the last byte so len=255 never wraps it.
        if (idx_q == len_q - 8'd1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  assign rd_en   = (state_q == READ);
  assign wr_en   = (state_q == WRITE);
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign rd_addr = src_q + ADDR_W'(idx_q);
  assign wr_addr = dst_q + ADDR_W'(idx_q);
  assign wr_data = wdata_q;

endmodule

// File: doc/rot_decode_ctrl.md
ROT_DECODE_CTRL -- requirements
Module: rot_decode_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the width of the source and destination byte address.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to decode a message; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: cancels the job in progress.
REQ-006 SHALL have ports src_base and dst_base, input, ADDR_W bits each: first read address and first write address.
REQ-007 SHALL have port msg_len, input, 8 bits: byte count, 0 to 255.
REQ-008 SHALL have port key, input, 4 bits: initial rotate-right amount; only key[2:0] is significant and key[3] is ignored.
REQ-009 SHALL have port key_step, input, 3 bits: per-byte increment of the rotate amount.
REQ-010 SHALL have ports rd_en (output, 1 bit) and rd_addr (output, ADDR_W bits): source memory read strobe and address.
REQ-011 SHALL have port rd_data, input, 8 bits: source byte, valid exactly one cycle after rd_en.
REQ-012 SHALL have ports wr_en (output, 1 bit), wr_addr (output, ADDR_W bits) and wr_data (output, 8 bits): destination write strobe, address and decoded byte.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a job completes normally.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, WAIT, WRITE and DONE.
REQ-016 SHALL, in IDLE with start=1, latch src_base, dst_base, msg_len, key[2:0] and key_step, clear index i to 0, and go to READ if msg_len!=0, otherwise go to DONE.
REQ-017 SHALL, in READ, drive rd_en=1 and rd_addr=src_base+i (modulo 2^ADDR_W), then go to WAIT.
REQ-018 SHALL, in WAIT, register the rotate-right of rd_data by the current amount rot into wr_data, then go to WRITE.
REQ-019 SHALL, in WRITE, drive wr_en=1 and wr_addr=dst_base+i (modulo 2^ADDR_W), update i=i+1 and rot=(rot+key_step) mod 8, then go to DONE if i was len-1, otherwise go to READ.
REQ-020 SHALL, in DONE, drive done=1 for exactly one cycle, then go to IDLE.
REQ-021 SHALL derive rd_en, wr_en, done and busy combinationally from the state register only.
REQ-022 SHALL meet this timing, with start sampled at edge 0: the first rd_en is in cycle 1; byte k is written in cycle 3+3k; done occurs in cycle 3*len+1; with len=0, done occurs in cycle 1.
REQ-023 SHALL ignore start while busy=1, with no effect on latched operands.
REQ-024 SHALL, when abort=1 is sampled in any non-IDLE state, go to IDLE at that edge with no done pulse; a strobe already asserted in that cycle completes.
REQ-025 SHALL give abort priority over start, so abort=1 and start=1 together in IDLE leave the block in IDLE.
REQ-026 SHALL, at msg_len=255, stop the 8-bit index at 254 when the last byte is written, with no overflow.

Reset
REQ-027 SHALL, on rst=1, immediately force state=IDLE; i=0; rot=0; wr_data=0x00; all latched operands 0; rd_en=wr_en=done=busy=0.
REQ-028 SHALL, on reset mid-job, discard the job with no done pulse and no further strobes.

Structure
REQ-029 SHALL place the FSM state enum and the constant ROT_W=3 in the shared package rot_pkg.
REQ-030 SHALL instantiate the existing 8-bit rotate-right shifter BarrelShifter as the only sub-module, driven with rot_amt {1'b0, rot} and rd_data.

Verification
REQ-031 SHALL cover: key=3, step=0, len=2, src bytes 0x81, 0x0F -> writes 0x30 then 0xE1; done in cycle 7.
REQ-032 SHALL cover: key=7, step=1, len=2, src bytes 0x81, 0x0F -> writes 0x03 (rot 7), then 0x0F (rot wraps to 0).
REQ-033 SHALL cover: key=4'b1001, len=1, src byte 0x01 -> writes 0x80 (key[3] ignored).
REQ-034 SHALL cover: len=0 -> done in cycle 1; rd_en and wr_en never asserted.
REQ-035 SHALL cover: src_base=0xFF, dst_base=0xFE, len=3 -> rd_addr 0xFF, 0x00, 0x01 and wr_addr 0xFE, 0xFF, 0x00.
REQ-036 SHALL cover: abort in cycle 4 of a len=4 job -> IDLE in cycle 5 with no done; a second start in cycle 4 is ignored; a new start in IDLE then runs normally.
